// File: rtl/ibex_avalon_pkg.sv
// Shared types for the Ibex data port to Avalon-MM bridge.
package ibex_avalon_pkg;

    typedef enum logic [1:0] {
        RespRead        = 2'd0,
        RespWriteAck    = 2'd1,
        RespWritePosted = 2'd2
    } resp_kind_e;

    localparam logic [1:0] AvmRespOkay = 2'b00;

endpackage

// File: rtl/ibex_avalon_resp_fifo.sv
// Small ordering FIFO holding the expected response kind of each issued command.
module ibex_avalon_resp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic [1:0],
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  T                push_data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output T                head_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= T'(0);
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ibex_avalon_data_bridge.sv
// Ibex data port (req/gnt/rvalid) to Avalon-MM pipelined master with bounded,
// in-order outstanding transactions and optional internal write acknowledge.
module ibex_avalon_data_bridge
    import ibex_avalon_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          UseWriteResp   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [1:0]  avm_response,
    input  logic        avm_writeresponsevalid,
    output logic        idle_o,
    output logic        protocol_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    resp_kind_e      head_kind;
    resp_kind_e      push_kind;
    logic            pop;
    logic            unexpected;
    logic            wr_resp_valid;
    logic            resp_err;

    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            protocol_err_q, protocol_err_d;

    assign avm_read       = data_req_i & ~data_we_i & ~fifo_full;
    assign avm_write      = data_req_i & data_we_i & ~fifo_full;
    assign avm_address    = data_addr_i;
    assign avm_byteenable = data_be_i;
    assign avm_writedata  = data_wdata_i;
    assign data_gnt_o     = (avm_read | avm_write) & ~avm_waitrequest;

    assign push_kind     = !data_we_i   ? RespRead :
                           UseWriteResp ? RespWriteAck : RespWritePosted;
    // Posted-write fabrics may leave writeresponsevalid floating; ignore it there.
    assign wr_resp_valid = UseWriteResp & avm_writeresponsevalid;
    assign resp_err      = (avm_response != AvmRespOkay);

    ibex_avalon_resp_fifo #(
        .Depth(MaxOutstanding),
        .T    (resp_kind_e)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (data_gnt_o),
        .push_data_i(push_kind),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_kind),
        .count_o    (fifo_count)
    );

    always_comb begin
        pop        = 1'b0;
        unexpected = 1'b0;
        if (fifo_empty) begin
            unexpected = avm_readdatavalid | wr_resp_valid;
        end else begin
            case (head_kind)
                RespRead: begin
                    pop        = avm_readdatavalid;
                    unexpected = wr_resp_valid;
                end
                RespWriteAck: begin
                    pop        = wr_resp_valid;
                    unexpected = avm_readdatavalid;
                end
                default: begin
                    pop        = 1'b1;
                    unexpected = avm_readdatavalid | wr_resp_valid;
                end
            endcase
        end
    end

    always_comb begin
        rvalid_d       = pop;
        rdata_d        = rdata_q;
        err_d          = err_q;
        protocol_err_d = protocol_err_q | unexpected;
        if (pop) begin
            rdata_d = (head_kind == RespRead) ? avm_readdata : '0;
            err_d   = (head_kind != RespWritePosted) && resp_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign data_err_o     = err_q;
    assign protocol_err_o = protocol_err_q;
    assign idle_o         = (fifo_count == '0) & ~rvalid_q;

endmodule

// File: tb/tb_ibex_avalon_data_bridge.sv
// Scoreboard bench: posted-write instance (_p) and write-response instance (_a).
module tb_ibex_avalon_data_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_p = 1'b0, req_a = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] addr = '0, wdata = '0;
    logic        waitreq = 1'b0;
    logic [31:0] rdata_in = '0;
    logic [1:0]  resp = 2'b00;
    logic        rdv_p = 1'b0, rdv_a = 1'b0, wrv_p = 1'b0, wrv_a = 1'b0;

    logic        gnt_p, rvalid_p, err_p, avm_rd_p, avm_wr_p, idle_p, perr_p;
    logic [31:0] rdata_p, avm_addr_p, avm_wd_p;
    logic [3:0]  avm_be_p;
    logic        gnt_a, rvalid_a, err_a, avm_rd_a, avm_wr_a, idle_a, perr_a;
    logic [31:0] rdata_a, avm_addr_a, avm_wd_a;
    logic [3:0]  avm_be_a;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_p[$];
    exp_t exp_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_avalon_data_bridge #(.MaxOutstanding(2), .UseWriteResp(1'b0)) u_post (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(req_p), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_gnt_o(gnt_p), .data_rvalid_o(rvalid_p),
        .data_rdata_o(rdata_p), .data_err_o(err_p),
        .avm_address(avm_addr_p), .avm_byteenable(avm_be_p), .avm_writedata(avm_wd_p),
        .avm_read(avm_rd_p), .avm_write(avm_wr_p), .avm_waitrequest(waitreq),
        .avm_readdata(rdata_in), .avm_readdatavalid(rdv_p), .avm_response(resp),
        .avm_writeresponsevalid(wrv_p), .idle_o(idle_p), .protocol_err_o(perr_p)
    );

    ibex_avalon_data_bridge #(.MaxOutstanding(2), .UseWriteResp(1'b1)) u_ack (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(req_a), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_gnt_o(gnt_a), .data_rvalid_o(rvalid_a),
        .data_rdata_o(rdata_a), .data_err_o(err_a),
        .avm_address(avm_addr_a), .avm_byteenable(avm_be_a), .avm_writedata(avm_wd_a),
        .avm_read(avm_rd_a), .avm_write(avm_wr_a), .avm_waitrequest(waitreq),
        .avm_readdata(rdata_in), .avm_readdatavalid(rdv_a), .avm_response(resp),
        .avm_writeresponsevalid(wrv_a), .idle_o(idle_a), .protocol_err_o(perr_a)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every response pulse must match the oldest expectation, cycle included.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_p) begin
            if (exp_p.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL post_unexpected_rvalid: got rvalid rdata %h err %b expected none (cycle %0d)",
                         rdata_p, err_p, cyc);
            end else begin
                e = exp_p.pop_front();
                check("post_rvalid_cycle", cyc, e.cyc);
                check("post_rdata", rdata_p, e.rdata);
                check("post_err", err_p, e.err);
            end
        end
        if (rvalid_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ack_unexpected_rvalid: got rvalid rdata %h err %b expected none (cycle %0d)",
                         rdata_a, err_a, cyc);
            end else begin
                e = exp_a.pop_front();
                check("ack_rvalid_cycle", cyc, e.cyc);
                check("ack_rdata", rdata_a, e.rdata);
                check("ack_err", err_a, e.err);
            end
        end
    end

    task automatic push_p(input int c, input logic [31:0] d, input logic e);
        exp_p.push_back('{cyc: c, rdata: d, err: e});
    endtask

    task automatic push_a(input int c, input logic [31:0] d, input logic e);
        exp_a.push_back('{cyc: c, rdata: d, err: e});
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset values
        next_cycle();
        next_cycle();
        sample();
        check("rst_rvalid", rvalid_p, 0);
        check("rst_rdata", rdata_p, 0);
        check("rst_err", err_p, 0);
        check("rst_perr", perr_p, 0);
        check("rst_idle", idle_p, 1);
        check("rst_idle_ack", idle_a, 1);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Single read, data two cycles after grant
        req_p = 1; we = 0; addr = 32'h1000_0010;
        sample();
        check("rd_avm_read", avm_rd_p, 1);
        check("rd_gnt", gnt_p, 1);
        check("rd_addr", avm_addr_p, 32'h1000_0010);
        next_cycle();
        req_p = 0;
        sample();
        check("rd_idle_busy", idle_p, 0);
        next_cycle();
        rdata_in = 32'hDEAD_BEEF; resp = 2'b00; rdv_p = 1;
        push_p(cyc + 1, 32'hDEAD_BEEF, 0);
        next_cycle();
        rdv_p = 0;
        next_cycle();
        sample();
        check("rd_idle_done", idle_p, 1);
        check("rd_rdata_hold", rdata_p, 32'hDEAD_BEEF);

        // Posted write, acknowledged two cycles after grant
        next_cycle();
        req_p = 1; we = 1; addr = 32'h2000_0000; wdata = 32'h5555_AAAA;
        sample();
        check("pw_avm_write", avm_wr_p, 1);
        check("pw_wdata", avm_wd_p, 32'h5555_AAAA);
        check("pw_gnt", gnt_p, 1);
        push_p(cyc + 2, 32'h0, 0);
        next_cycle();
        req_p = 0;
        next_cycle();
        next_cycle();
        next_cycle();

        // Three reads against two outstanding slots
        req_p = 1; we = 0; addr = 32'hA;
        sample();
        check("bb_gnt_a", gnt_p, 1);
        next_cycle();
        addr = 32'hB;
        sample();
        check("bb_gnt_b", gnt_p, 1);
        next_cycle();
        addr = 32'hC;
        sample();
        check("bb_full_read", avm_rd_p, 0);
        check("bb_full_gnt", gnt_p, 0);
        next_cycle();
        sample();
        check("bb_full_gnt2", gnt_p, 0);
        next_cycle();
        rdv_p = 1; rdata_in = 32'hAAAA_0001; resp = 2'b00;
        push_p(cyc + 1, 32'hAAAA_0001, 0);
        sample();
        check("bb_pop_still_full", avm_rd_p, 0);
        check("bb_pop_no_gnt", gnt_p, 0);
        next_cycle();
        rdv_p = 0;
        sample();
        check("bb_c_read", avm_rd_p, 1);
        check("bb_c_gnt", gnt_p, 1);
        next_cycle();
        req_p = 0; rdv_p = 1; rdata_in = 32'hBBBB_0002;
        push_p(cyc + 1, 32'hBBBB_0002, 0);
        next_cycle();
        rdata_in = 32'hCCCC_0003; resp = 2'b01;
        push_p(cyc + 1, 32'hCCCC_0003, 1);
        next_cycle();
        rdv_p = 0; resp = 2'b00;
        next_cycle();
        next_cycle();

        // Write with error response, then read, on the write-response instance
        req_a = 1; we = 1; addr = 32'h3000_0000; wdata = 32'h1111_2222;
        sample();
        check("wa_gnt_w", gnt_a, 1);
        next_cycle();
        we = 0; addr = 32'h3000_0004;
        sample();
        check("wa_gnt_r", gnt_a, 1);
        next_cycle();
        req_a = 0; wrv_a = 1; resp = 2'b10;
        push_a(cyc + 1, 32'h0, 1);
        next_cycle();
        wrv_a = 0; rdv_a = 1; resp = 2'b00; rdata_in = 32'hCAFE_F00D;
        push_a(cyc + 1, 32'hCAFE_F00D, 0);
        next_cycle();
        rdv_a = 0;
        next_cycle();
        next_cycle();

        // Read data with nothing outstanding
        rdv_p = 1; rdata_in = 32'h0BAD_0BAD;
        next_cycle();
        rdv_p = 0;
        sample();
        check("pe_set", perr_p, 1);
        check("pe_other_clear", perr_a, 0);
        next_cycle();
        next_cycle();
        sample();
        check("pe_sticky", perr_p, 1);

        // Write response while a read heads the queue
        next_cycle();
        req_a = 1; we = 0; addr = 32'h3000_0008;
        sample();
        check("mm_gnt", gnt_a, 1);
        next_cycle();
        req_a = 0; wrv_a = 1;
        next_cycle();
        wrv_a = 0;
        sample();
        check("mm_perr", perr_a, 1);
        next_cycle();
        rdv_a = 1; rdata_in = 32'h1234_5678;
        push_a(cyc + 1, 32'h1234_5678, 0);
        next_cycle();
        rdv_a = 0;
        next_cycle();

        // Stall for five cycles; command must hold steady
        waitreq = 1; req_p = 1; we = 1; addr = 32'h4000_0040; wdata = 32'h7777_8888;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("ws_no_gnt", gnt_p, 0);
            check("ws_write", avm_wr_p, 1);
            check("ws_addr", avm_addr_p, 32'h4000_0040);
            check("ws_wdata", avm_wd_p, 32'h7777_8888);
            next_cycle();
        end
        waitreq = 0;
        sample();
        check("ws_gnt", gnt_p, 1);
        push_p(cyc + 2, 32'h0, 0);
        next_cycle();
        req_p = 0;
        next_cycle();
        next_cycle();
        next_cycle();
        sample();
        check("pe_sticky_late", perr_p, 1);

        // Reset with a read outstanding; its late response is stray
        next_cycle();
        req_p = 1; we = 0; addr = 32'h5000_0000;
        next_cycle();
        req_p = 0;
        rst_n = 0;
        sample();
        check("mr_perr_clr", perr_p, 0);
        check("mr_idle", idle_p, 1);
        next_cycle();
        rst_n = 1;
        next_cycle();
        rdv_p = 1; rdata_in = 32'h9999_9999;
        next_cycle();
        rdv_p = 0;
        sample();
        check("mr_stray_perr", perr_p, 1);
        next_cycle();
        next_cycle();

        checks++;
        if (exp_p.size() != 0) begin
            failures++;
            $display("FAIL post_drain: got %0d pending expected 0", exp_p.size());
        end
        checks++;
        if (exp_a.size() != 0) begin
            failures++;
            $display("FAIL ack_drain: got %0d pending expected 0", exp_a.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
